// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : Bank of independent up-counters behind one registered,
//               round-robin arbitrated read-data bus. Optional saturation is
//               enabled by defining COUNTER_BANK_SAT_EN (default: wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] clear,
  input  logic [CHANNELS-1:0] read_req,
  output logic [CHANNELS-1:0] read_ack,
  output logic [WIDTH-1:0]    data,
  output logic [CHW-1:0]      data_ch,
  output logic                data_valid,
  output logic                collision,
  output logic [CHANNELS-1:0] overflow
);

  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [CHW-1:0]   rr;
  logic [CHW-1:0]   rr_next;
  logic [CHW-1:0]   idx;
  logic [CHW-1:0]   gnt_idx;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_data;
  logic             multi_req;

  // Search upward from rr; the snapshot is taken from the pre-edge count so a
  // same-cycle clear or increment is not visible in the returned data.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    idx       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = CHW'((int'(rr) + k) % CHANNELS);
      if (!gnt_found && read_req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
        gnt_data  = cnt[idx];
      end
    end
    if (!gnt_found)
      rr_next = rr;
    else if (gnt_idx == CHW'(CHANNELS - 1))
      rr_next = '0;
    else
      rr_next = gnt_idx + CHW'(1);
    multi_req = ($countones(read_req) > 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr         <= '0;
      read_ack   <= '0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      collision  <= 1'b0;
      overflow   <= '0;
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= '0;
    end else begin
      rr         <= rr_next;
      data_valid <= gnt_found;
      data       <= gnt_data;
      data_ch    <= gnt_idx;
      read_ack   <= gnt_found ? (CHANNELS'(1) << gnt_idx) : '0;
      collision  <= multi_req;
      for (int i = 0; i < CHANNELS; i++) begin
        if (clear[i]) begin
          cnt[i]      <= '0;
          overflow[i] <= 1'b0;
        end else if (enable[i]) begin
          if (&cnt[i]) begin
            overflow[i] <= 1'b1;
`ifdef COUNTER_BANK_SAT_EN
            cnt[i]      <= cnt[i];
`else
            cnt[i]      <= '0;
`endif
          end else begin
            cnt[i] <= cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Scoreboard bench for counter_bank (2-channel and 4-channel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

`ifdef COUNTER_BANK_SAT_EN
  localparam logic [7:0] OVF_VAL = 8'hFF;
`else
  localparam logic [7:0] OVF_VAL = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] enable, clear, read_req, read_ack, overflow;
  logic [7:0] data;
  logic [0:0] data_ch;
  logic       data_valid, collision;

  logic [3:0] enable4, clear4, read_req4, read_ack4, overflow4;
  logic [7:0] data4;
  logic [1:0] data_ch4;
  logic       data_valid4, collision4;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(8), .CHANNELS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .read_req(read_req), .read_ack(read_ack), .data(data), .data_ch(data_ch),
    .data_valid(data_valid), .collision(collision), .overflow(overflow)
  );

  counter_bank #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable4), .clear(clear4),
    .read_req(read_req4), .read_ack(read_ack4), .data(data4), .data_ch(data_ch4),
    .data_valid(data_valid4), .collision(collision4), .overflow(overflow4)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    logic [3:0] ack;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic [1:0] ch, input logic [3:0] ack);
    exp_t r;
    r.d = d; r.ch = ch; r.ack = ack;
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b1; enable = '0; clear = '0; read_req = '0;
    enable4 = '0; clear4 = '0; read_req4 = '0;
    repeat (2) @(negedge clk);
    checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else passed++;
    checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else passed++;
    checks++; if (read_ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", read_ack); else passed++;
    checks++; if (data_ch !== 1'b0) $display("FAIL reset_ch: got %0d want 0", data_ch); else passed++;
    checks++; if (collision !== 1'b0) $display("FAIL reset_collision: got %b want 0", collision); else passed++;
    checks++; if (overflow !== 2'b00) $display("FAIL reset_overflow: got %b want 00", overflow); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic_count;
    enable = 2'b01;
    repeat (5) @(negedge clk);
    enable = 2'b00; read_req = 2'b01;
    sb.push_back(mk(8'd5, 2'd0, 4'b0001));
    @(negedge clk);
    read_req = 2'b00;
    e = sb.pop_front();
    checks++; if (data !== e.d) $display("FAIL basic_data: got %0d want %0d", data, e.d); else passed++;
    checks++; if (data_ch !== e.ch[0]) $display("FAIL basic_ch: got %0d want %0d", data_ch, e.ch); else passed++;
    checks++; if (read_ack !== e.ack[1:0]) $display("FAIL basic_ack: got %b want %b", read_ack, e.ack[1:0]); else passed++;
    checks++; if (data_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", data_valid); else passed++;
    @(negedge clk);
    checks++; if (data !== 8'h00 || data_valid !== 1'b0) $display("FAIL basic_idle: got data %h valid %b want 00/0", data, data_valid); else passed++;
  endtask

  task automatic test_simultaneous;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    enable = 2'b11; repeat (3) @(negedge clk);
    enable = 2'b10; repeat (4) @(negedge clk);
    enable = 2'b00; read_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(i == 0 ? mk(8'd3, 2'd0, 4'b0001) : mk(8'd7, 2'd1, 4'b0010));
      @(negedge clk);
      if (i == 1) read_req = 2'b00;
      e = sb.pop_front();
      checks++; if (data !== e.d) $display("FAIL simul_data[%0d]: got %h want %h", i, data, e.d); else passed++;
      checks++; if (data_ch !== e.ch[0]) $display("FAIL simul_ch[%0d]: got %0d want %0d", i, data_ch, e.ch); else passed++;
      checks++; if (read_ack !== e.ack[1:0]) $display("FAIL simul_ack[%0d]: got %b want %b", i, read_ack, e.ack[1:0]); else passed++;
      checks++; if (collision !== 1'b1) $display("FAIL simul_collision[%0d]: got %b want 1", i, collision); else passed++;
      checks++; if ($isunknown(data)) $display("FAIL simul_noX[%0d]: got %h want known", i, data); else passed++;
    end
    @(negedge clk);
    checks++; if (collision !== 1'b0 || data_valid !== 1'b0) $display("FAIL simul_idle: got col %b valid %b want 0/0", collision, data_valid); else passed++;
  endtask

  task automatic test_round_robin;
    read_req4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(8'd0, 2'(i % 4), 4'(1 << (i % 4))));
      @(negedge clk);
      if (i == 7) read_req4 = 4'h0;
      e = sb.pop_front();
      checks++; if (data_ch4 !== e.ch) $display("FAIL rr_ch[%0d]: got %0d want %0d", i, data_ch4, e.ch); else passed++;
      checks++; if (read_ack4 !== e.ack) $display("FAIL rr_ack[%0d]: got %b want %b", i, read_ack4, e.ack); else passed++;
      checks++; if (data4 !== e.d || data_valid4 !== 1'b1) $display("FAIL rr_data[%0d]: got %h/%b want %h/1", i, data4, data_valid4, e.d); else passed++;
    end
  endtask

  task automatic test_clear_vs_read;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    enable = 2'b01; repeat (9) @(negedge clk);
    enable = 2'b00; clear = 2'b01; read_req = 2'b01;
    sb.push_back(mk(8'd9, 2'd0, 4'b0001));
    @(negedge clk);
    clear = 2'b00; read_req = 2'b00;
    e = sb.pop_front();
    checks++; if (data !== e.d || data_valid !== 1'b1) $display("FAIL clrrd_data: got %0d/%b want %0d/1", data, data_valid, e.d); else passed++;
    read_req = 2'b01;
    sb.push_back(mk(8'd0, 2'd0, 4'b0001));
    @(negedge clk);
    read_req = 2'b00;
    e = sb.pop_front();
    checks++; if (data !== e.d || read_ack !== e.ack[1:0]) $display("FAIL clrrd_after: got %0d/%b want %0d/%b", data, read_ack, e.d, e.ack[1:0]); else passed++;
  endtask

  task automatic test_overflow;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    enable = 2'b01;
    repeat (255) @(negedge clk);
    checks++; if (overflow !== 2'b00) $display("FAIL ovf_early: got %b want 00", overflow); else passed++;
    @(negedge clk);
    enable = 2'b00;
    checks++; if (overflow !== 2'b01) $display("FAIL ovf_set: got %b want 01", overflow); else passed++;
    read_req = 2'b01;
    sb.push_back(mk(OVF_VAL, 2'd0, 4'b0001));
    @(negedge clk);
    read_req = 2'b00;
    e = sb.pop_front();
    checks++; if (data !== e.d) $display("FAIL ovf_count: got %h want %h", data, e.d); else passed++;
    clear = 2'b01;
    @(negedge clk);
    clear = 2'b00;
    checks++; if (overflow !== 2'b00) $display("FAIL ovf_clear: got %b want 00", overflow); else passed++;
  endtask

  task automatic test_mid_read_reset;
    enable = 2'b11; repeat (4) @(negedge clk);
    enable = 2'b00; reset = 1'b1; read_req = 2'b11;
    @(negedge clk);
    reset = 1'b0; read_req = 2'b00;
    checks++; if (data_valid !== 1'b0 || read_ack !== 2'b00 || data !== 8'h00) $display("FAIL midrst_out: got valid %b ack %b data %h want 0/00/00", data_valid, read_ack, data); else passed++;
    read_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(8'd0, 2'(i), 4'(1 << i)));
      @(negedge clk);
      if (i == 1) read_req = 2'b00;
      e = sb.pop_front();
      checks++; if (data !== e.d || data_ch !== e.ch[0] || data_valid !== 1'b1) $display("FAIL midrst_read[%0d]: got %h ch %0d valid %b want %h ch %0d valid 1", i, data, data_ch, data_valid, e.d, e.ch); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_simultaneous();
    test_round_robin();
    test_clear_vs_read();
    test_overflow();
    test_mid_read_reset();
    checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of `CHANNELS` independent up-counters sharing one registered read-data bus. Per-channel count enable, clear and read request. A round-robin arbiter grants exactly one read per cycle, so simultaneous reads can never drive the bus to X. The bank sits between the count-event sources and any single-bus consumer, and replaces instantiating several counters on a shared tri-state bus.

## Interface
- `WIDTH`, 8, counter and data bus width in bits (2..32)
- `CHANNELS`, 2, number of counters (1..16)
- Local `CHW` = max(1, $clog2(CHANNELS)), channel index width

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  CHANNELS  per-channel count enable; +1 per cycle while high
- `clear`  in  CHANNELS  per-channel synchronous clear of count and overflow
- `read_req`  in  CHANNELS  per-channel read request, level-sensitive
- `read_ack`  out  CHANNELS  one-hot grant, registered
- `data`  out  WIDTH  snapshot of the granted counter, registered
- `data_ch`  out  CHW  index of the granted channel
- `data_valid`  out  1  `data`/`data_ch` valid this cycle
- `collision`  out  1  registered pulse: more than one `read_req` bit was high in the sampled cycle
- `overflow`  out  CHANNELS  sticky flag per channel, set on count past all-ones

## Operation
- Counter i, per cycle, in priority order: `reset` → 0; `clear[i]` → 0; `enable[i]` → count+1 (wrap or saturate, see Configuration); else hold.
- `overflow[i]`: set when `enable[i]` is high with count == all-ones and no clear. Cleared only by `reset` or `clear[i]`. Clear wins over a same-cycle overflow event.
- Arbiter: a round-robin pointer `rr` (CHW bits) selects the first requesting channel at or after `rr`, searching upward modulo CHANNELS.
  - On a grant to channel g, `rr` ← (g+1) mod CHANNELS.
  - With no request, `rr` holds.
  - Requests are level-sensitive. A channel holding `read_req` high is granted again on its next round-robin turn. The requester drops `read_req` after seeing `read_ack`.
- Snapshot: `data` captures the granted counter's value at the request-sampling edge, before that edge's increment or clear takes effect. A read and a clear in the same cycle therefore return the pre-clear value.
- `data` is 0 and `data_ch` is 0 whenever `data_valid` is 0. The bus is never X or Z.
- `collision` is informational only. Arbitration still grants exactly one channel.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no decrement.

## Timing
- Reset values: all counters 0, `overflow` 0, `read_ack` 0, `data` 0, `data_ch` 0, `data_valid` 0, `collision` 0, `rr` 0.
- Read latency is 1 cycle. If `read_req` is sampled at edge N, then `read_ack`, `data`, `data_ch` and `data_valid` are asserted after edge N and held until edge N+1.
- Throughput is one read per cycle, across all channels combined.
- Count latency: `enable` high at edge N gives the incremented value after edge N.
- `reset` asserted in the middle of a read: the outputs return to reset values after the same edge, and the pending grant is lost.
- CHANNELS=1: the arbiter degenerates to a pass-through, `rr` is constant 0, and `collision` is never set.

## Configuration
- `COUNTER_BANK_SAT_EN` defined: a counter at all-ones with `enable` high holds at all-ones. `overflow` is set.
- `COUNTER_BANK_SAT_EN` undefined (default): the counter wraps from all-ones to 0. `overflow` is set on the wrap.

## Test plan
- Reset and basic count: hold `reset`=1 for 2 cycles, then release. `enable[0]`=1 for 5 cycles, then `read_req[0]` for 1 cycle → `data`=5, `data_ch`=0, `data_valid`=1 one cycle later, `read_ack`=2'b01; `data`=0 on the cycle after.
- Simultaneous read: counters at 3 and 7; `read_req`=2'b11 held for 2 cycles → first cycle: `data_ch`=0, `data`=3, `collision`=1; second cycle: `data_ch`=1, `data`=7; no X on `data` in any cycle.
- Round-robin fairness: CHANNELS=4, all `read_req` held for 8 cycles → `data_ch` sequence 0,1,2,3,0,1,2,3.
- Clear versus read: counter 0 at 9; `clear[0]` and `read_req[0]` in the same cycle → `data`=9 returned; counter reads 0 on the next read.
- Overflow, WIDTH=8: 256 enables from 0 → default build: count 0 and `overflow[0]`=1; with `COUNTER_BANK_SAT_EN`: count 255 and `overflow[0]`=1; `clear[0]` → `overflow[0]`=0.
- Mid-read reset: assert `reset` in the same cycle as `read_req` → `data_valid` stays 0, all counters read 0 afterward.
